// File: rtl/forward_hazard_unit.sv
// Purpose: EX/MEM operand forwarding, load-use stall and branch flush for the 64-bit pipeline.
// Latency: forwarding, stall and flush are same-cycle combinational; MEM slot lags EX by one cycle.
// Backpressure: stall holds PC and IF/ID for exactly one cycle per load-use event; flush wins over stall.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ex_*                  EX-stage result, destination, write/load/forwardable flags, taken branch
//   mem_data              MEM-stage writeback value
//   id_rn/id_rm           ID source registers, id_rf_da/id_rf_db their register-file values
//   fwd_da/fwd_db         operands delivered to EX, fwd_sel_a/b: 00 RF, 01 EX, 10 MEM
//   stall, flush          hazard controls, stall_count saturating count of stall cycles
module forward_hazard_unit #(
  parameter logic [4:0] XZR_IDX = 5'd31,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      ex_result,
  input  logic [4:0]       ex_rd,
  input  logic             ex_fwd_en,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_br_taken,
  input  logic [63:0]      mem_data,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [63:0]      id_rf_da,
  input  logic [63:0]      id_rf_db,
  output logic [63:0]      fwd_da,
  output logic [63:0]      fwd_db,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  state_t     state;
  logic [4:0] mem_rd;
  logic       mem_wr;
  logic       ex_live;
  logic       hz;
  logic       bubble;

  // While stalled the EX stage holds a bubble, so its inputs are ignored.
  assign ex_live = (state == IDLE);

  assign hz = ex_live & ex_regwrite & ex_memtoreg & (ex_rd != XZR_IDX)
            & ((ex_rd == id_rn) | (ex_rd == id_rm));

  assign flush  = ex_br_taken;
  assign stall  = hz & ~ex_br_taken;
  // A flushed or stalled EX slot must not become a writing MEM slot.
  assign bubble = (state == STALL) | flush;

  // Source select; EX match beats MEM match, the zero register never forwards.
  function automatic logic [1:0] pick_src(
    input logic [4:0] rs,
    input logic       live,
    input logic       fwd_en,
    input logic [4:0] erd,
    input logic       mwr,
    input logic [4:0] mrd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (rs == XZR_IDX)                      sel = SEL_RF;
    else if (live && fwd_en && (erd == rs)) sel = SEL_EX;
    else if (mwr && (mrd == rs))            sel = SEL_MEM;
    return sel;
  endfunction

  assign fwd_sel_a = pick_src(id_rn, ex_live, ex_fwd_en, ex_rd, mem_wr, mem_rd);
  assign fwd_sel_b = pick_src(id_rm, ex_live, ex_fwd_en, ex_rd, mem_wr, mem_rd);

  always_comb begin
    fwd_da = id_rf_da;
    case (fwd_sel_a)
      SEL_EX:  fwd_da = ex_result;
      SEL_MEM: fwd_da = mem_data;
      default: fwd_da = id_rf_da;
    endcase
  end

  always_comb begin
    fwd_db = id_rf_db;
    case (fwd_sel_b)
      SEL_EX:  fwd_db = ex_result;
      SEL_MEM: fwd_db = mem_data;
      default: fwd_db = id_rf_db;
    endcase
  end

  // MEM slot and stall FSM; a stall always lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mem_rd <= 5'd0;
      mem_wr <= 1'b0;
    end else begin
      mem_rd <= ex_rd;
      mem_wr <= ex_regwrite & ~bubble;
      case (state)
        IDLE:    state <= stall ? STALL : IDLE;
        STALL:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ex_result, mem_data, id_rf_da, id_rf_db;
  logic [4:0]  ex_rd, id_rn, id_rm;
  logic        ex_fwd_en, ex_regwrite, ex_memtoreg, ex_br_taken;

  logic [63:0] fwd_da, fwd_db, fwd_da_s, fwd_db_s;
  logic [1:0]  sel_a, sel_b, sel_a_s, sel_b_s;
  logic        stall, flush, stall_s, flush_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the pipeline looks like from the rules.
  bit         m_stalled;   // current cycle is the bubble following a stall
  bit         m_wr;        // previous EX instruction really writes a register
  logic [4:0] m_rd;
  int         m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  forward_hazard_unit dut (
    .clk(clk), .reset(reset), .ex_result(ex_result), .ex_rd(ex_rd),
    .ex_fwd_en(ex_fwd_en), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_br_taken(ex_br_taken), .mem_data(mem_data), .id_rn(id_rn), .id_rm(id_rm),
    .id_rf_da(id_rf_da), .id_rf_db(id_rf_db), .fwd_da(fwd_da), .fwd_db(fwd_db),
    .fwd_sel_a(sel_a), .fwd_sel_b(sel_b), .stall(stall), .flush(flush),
    .stall_count(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  forward_hazard_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .ex_result(ex_result), .ex_rd(ex_rd),
    .ex_fwd_en(ex_fwd_en), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_br_taken(ex_br_taken), .mem_data(mem_data), .id_rn(id_rn), .id_rm(id_rm),
    .id_rf_da(id_rf_da), .id_rf_db(id_rf_db), .fwd_da(fwd_da_s), .fwd_db(fwd_db_s),
    .fwd_sel_a(sel_a_s), .fwd_sel_b(sel_b_s), .stall(stall_s), .flush(flush_s),
    .stall_count(cnt_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_src(input logic [4:0] rs, input logic [63:0] rf,
                                    output logic [63:0] v, output logic [1:0] s);
    if (rs == 5'd31) begin
      v = rf; s = 2'b00;
    end else if (!m_stalled && ex_fwd_en && ex_rd == rs) begin
      v = ex_result; s = 2'b01;
    end else if (m_wr && m_rd == rs) begin
      v = mem_data; s = 2'b10;
    end else begin
      v = rf; s = 2'b00;
    end
  endfunction

  function automatic bit model_stall();
    return !m_stalled && ex_regwrite && ex_memtoreg && ex_rd != 5'd31 &&
           (ex_rd == id_rn || ex_rd == id_rm) && !ex_br_taken;
  endfunction

  task automatic model_reset();
    m_stalled = 0; m_wr = 0; m_rd = 5'd0; m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic check_model();
    logic [63:0] va, vb;
    logic [1:0]  sa, sb;
    model_src(id_rn, id_rf_da, va, sa);
    model_src(id_rm, id_rf_db, vb, sb);
    check("fwd_da", fwd_da, va);
    check("fwd_db", fwd_db, vb);
    check("fwd_sel_a", 64'(sel_a), 64'(sa));
    check("fwd_sel_b", 64'(sel_b), 64'(sb));
    check("stall", 64'(stall), 64'(model_stall()));
    check("flush", 64'(flush), 64'(ex_br_taken));
    check("stall_count", 64'(cnt), 64'(m_cnt));
    check("fwd_da_s", fwd_da_s, va);
    check("fwd_db_s", fwd_db_s, vb);
    check("fwd_sel_a_s", 64'(sel_a_s), 64'(sa));
    check("fwd_sel_b_s", 64'(sel_b_s), 64'(sb));
    check("stall_s", 64'(stall_s), 64'(model_stall()));
    check("flush_s", 64'(flush_s), 64'(ex_br_taken));
    check("stall_count_s", 64'(cnt_s), 64'(m_cnt_s));
  endtask

  // Called at posedge+1 after inputs are set; returns at the next posedge+1.
  task automatic advance();
    bit st;
    st = model_stall();
    @(posedge clk);
    m_wr      = ex_regwrite && !m_stalled && !ex_br_taken;
    m_rd      = ex_rd;
    m_stalled = st;
    if (st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 15) m_cnt_s++;
    end
    #1;
  endtask

  task automatic step();
    #4;
    check_model();
    advance();
  endtask

  task automatic set_idle();
    ex_result   = {$urandom, $urandom};
    mem_data    = {$urandom, $urandom};
    id_rf_da    = {$urandom, $urandom};
    id_rf_db    = {$urandom, $urandom};
    ex_rd       = 5'd0;
    id_rn       = 5'd0;
    id_rm       = 5'd0;
    ex_fwd_en   = 0;
    ex_regwrite = 0;
    ex_memtoreg = 0;
    ex_br_taken = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    set_idle();
    ex_rd = rd; ex_regwrite = 1; ex_memtoreg = 1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd2;
      1:       return 5'd3;
      2:       return 5'd5;
      3:       return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    reset = 0;
    set_idle();
    model_reset();
    // Held in reset across edges with a writing EX instruction: MEM slot must stay empty.
    ex_regwrite = 1; ex_fwd_en = 1; ex_rd = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 64'(cnt), 64'd0);
    check("reset_flush", 64'(flush), 64'd0);
    reset = 1;
    ex_regwrite = 0; ex_fwd_en = 0; id_rn = 5'd7;
    #4;
    check("post_reset_no_mem_fwd", 64'(sel_a), 64'd0);
    check_model();
    advance();

    // EX forward.
    set_idle();
    ex_fwd_en = 1; ex_regwrite = 1; ex_rd = 5'd3; ex_result = 64'h1234;
    id_rn = 5'd3; id_rm = 5'd4;
    #4;
    check("ex_fwd_da", fwd_da, 64'h1234);
    check("ex_fwd_sel_a", 64'(sel_a), 64'd1);
    check("ex_fwd_db_rf", fwd_db, id_rf_db);
    check("ex_fwd_sel_b", 64'(sel_b), 64'd0);
    check("ex_fwd_stall", 64'(stall), 64'd0);
    check_model();
    advance();

    // MEM forward and EX priority.
    set_idle();
    ex_fwd_en = 1; ex_regwrite = 1; ex_rd = 5'd5; ex_result = 64'd7;
    step();
    set_idle();
    ex_fwd_en = 1; ex_regwrite = 1; ex_rd = 5'd5; ex_result = 64'd9;
    mem_data = 64'd7; id_rn = 5'd5;
    #4;
    check("prio_ex_wins", fwd_da, 64'd9);
    check("prio_sel", 64'(sel_a), 64'd1);
    check_model();
    advance();
    set_idle();
    mem_data = 64'd9; id_rn = 5'd5;
    #4;
    check("mem_fwd_da", fwd_da, 64'd9);
    check("mem_fwd_sel", 64'(sel_a), 64'd2);
    check_model();
    advance();

    // Load-use.
    set_load(5'd2);
    id_rn = 5'd6; id_rm = 5'd2;
    #4;
    check("lu_stall", 64'(stall), 64'd1);
    check_model();
    advance();
    check("lu_count", 64'(cnt), 64'd1);
    id_rm = 5'd2; mem_data = 64'hABC;
    #4;
    check("lu_stall_drop", 64'(stall), 64'd0);
    check("lu_sel_b", 64'(sel_b), 64'd2);
    check("lu_fwd_db", fwd_db, 64'hABC);
    check_model();
    advance();

    // Branch beats hazard.
    set_load(5'd2);
    id_rm = 5'd2; ex_br_taken = 1;
    #4;
    check("br_flush", 64'(flush), 64'd1);
    check("br_no_stall", 64'(stall), 64'd0);
    check_model();
    advance();
    set_idle();
    id_rn = 5'd2;
    #4;
    check("br_count_same", 64'(cnt), 64'd1);
    check("br_mem_wr_clear", 64'(sel_a), 64'd0);
    check_model();
    advance();

    // Zero register.
    set_idle();
    ex_rd = 5'd31; ex_fwd_en = 1; ex_regwrite = 1; id_rn = 5'd31;
    #4;
    check("xzr_sel", 64'(sel_a), 64'd0);
    check("xzr_val", fwd_da, id_rf_da);
    check_model();
    advance();
    set_load(5'd31);
    id_rn = 5'd31;
    #4;
    check("xzr_no_stall", 64'(stall), 64'd0);
    check("xzr_mem_sel", 64'(sel_a), 64'd0);
    check_model();
    advance();

    // Reset in the middle of a stall with stall_count = 5.
    reset = 0;
    model_reset();
    #2;
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      set_load(5'd2);
      id_rm = 5'd2;
      step();
      if (i < 4) begin
        set_idle();
        step();
      end
    end
    check("pre_reset_count", 64'(cnt), 64'd5);
    set_load(5'd2);
    id_rn = 5'd2; id_rm = 5'd2;
    #2;
    check("in_stall_no_stall", 64'(stall), 64'd0);
    check("in_stall_mem_sel", 64'(sel_b), 64'd2);
    reset = 0;
    model_reset();
    #1;
    check("async_count_clear", 64'(cnt), 64'd0);
    check("async_idle_stall", 64'(stall), 64'd1);
    check("async_mem_wr_clear", 64'(sel_a), 64'd0);
    #1;
    check_model();
    @(posedge clk);
    #1;
    reset = 1;
    set_idle();
    id_rn = 5'd2;
    step();

    // Saturation of the narrow counter.
    for (int i = 0; i < 20; i++) begin
      set_load(5'd3);
      id_rn = 5'd3;
      step();
      set_idle();
      step();
    end
    check("sat_narrow", 64'(cnt_s), 64'hF);
    check("sat_wide_count", 64'(cnt), 64'd20);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      ex_rd       = pick_reg();
      id_rn       = pick_reg();
      id_rm       = ($urandom_range(0, 3) == 0) ? id_rn : pick_reg();
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_memtoreg = 1'($urandom_range(0, 1));
      ex_fwd_en   = ex_regwrite & ~ex_memtoreg;
      ex_br_taken = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Forwarding and hazard unit between the register-read (ID) stage and the EX stage of the pipelined 64-bit CPU. It takes the EX stage's result/destination/forward-enable/branch outputs and tracks one registered MEM-stage slot. From these it supplies forwarded A/B operands to ID, detects load-use hazards (one-cycle stall), and raises flush on taken branches. A saturating stall counter provides performance visibility.

## Interface
Parameters:
- XZR_IDX, 31, register index that is never forwarded (zero register)
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- ex_result  in  64  EX-stage ALU/shift result
- ex_rd  in  5  EX-stage destination register
- ex_fwd_en  in  1  EX result is forwardable (RegWrite & ~MemToReg)
- ex_regwrite  in  1  EX instruction writes a register
- ex_memtoreg  in  1  EX instruction is a load
- ex_br_taken  in  1  EX-stage PC_select (taken branch)
- mem_data  in  64  MEM-stage writeback value (load data or passed-through ALU result)
- id_rn, id_rm  in  5 each  ID-stage source registers for A and B
- id_rf_da, id_rf_db  in  64 each  register-file read data for A and B
- fwd_da, fwd_db  out  64 each  operands delivered to EX
- fwd_sel_a, fwd_sel_b  out  2 each  00 = RF, 01 = EX, 10 = MEM
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- flush  out  1  kill the instruction in IF/ID
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- MEM slot registers, updated every posedge: mem_rd <= ex_rd; mem_wr <= ex_regwrite & ~bubble, where bubble = (state == STALL) | flush.
- Operand A select, evaluated per source; B is identical using id_rm/id_rf_db:
  - If id_rn == XZR_IDX: sel 00, RF value.
  - Else if state == IDLE & ex_fwd_en & ex_rd == id_rn: sel 01, ex_result.
  - Else if mem_wr & mem_rd == id_rn: sel 10, mem_data.
  - Else: sel 00, RF value.
  - EX match has priority over MEM match.
- Load-use hazard: hz = (state == IDLE) & ex_regwrite & ex_memtoreg & ex_rd != XZR_IDX & (ex_rd == id_rn | ex_rd == id_rm).
- Hazard outputs:
  - stall = hz & ~ex_br_taken.
  - flush = ex_br_taken; flush wins over stall.
- FSM, two states:
  - IDLE -> STALL when stall = 1.
  - STALL -> IDLE unconditionally on the next edge. The load has moved to the MEM slot, and the EX inputs are treated as a bubble.
  - In STALL, the EX inputs are ignored for forwarding and hazard detection, and stall = 0.
- stall_count increments on each posedge where stall = 1 and saturates at all-ones.

## Timing
- Forwarding muxes, fwd_sel_*, stall and flush are combinational from the inputs and registered state (same-cycle).
- The MEM slot lags EX by exactly 1 cycle.
- A stall lasts exactly 1 cycle per load-use event. Back-to-back dependent loads each produce their own single stall.
- Reset (asserted low, asynchronous) forces:
  - state = IDLE, mem_wr = 0, mem_rd = 0, stall_count = 0.
  - Outputs then follow the combinational rules: stall = 0 unless hz; flush = ex_br_taken.
- Reset mid-stall aborts the stall immediately. No forwarding from MEM occurs on the first cycle after reset release.
- Same register in both sources: both A and B forward identically.
- Rd == XZR_IDX: never forwarded and never stalls.

## Test plan
- EX forward: ex_fwd_en = 1, ex_rd = 3, ex_result = 0x1234, id_rn = 3, id_rm = 4 -> fwd_da = 0x1234, fwd_sel_a = 01, fwd_db = id_rf_db, fwd_sel_b = 00, stall = 0.
- MEM forward and priority: cycle 0 EX writes X5 (value 7); cycle 1 EX writes X5 (value 9), mem_data = 7, id_rn = 5 -> fwd_da = 9 (EX wins). Cycle 2 with EX not writing -> fwd_da = mem_data, sel 10.
- Load-use: EX load to X2, id_rm = 2 -> stall = 1 for one cycle and stall_count = 1. Next cycle: state STALL, stall = 0, fwd_sel_b = 10, fwd_db = mem_data.
- Branch vs hazard: load-use condition together with ex_br_taken = 1 -> flush = 1, stall = 0, stall_count unchanged, and the next cycle's mem_wr = 0.
- XZR: ex_rd = 31, ex_fwd_en = 1, id_rn = 31 -> sel 00, RF value. Load to X31 with id_rn = 31 -> no stall.
- Reset: assert reset low during STALL with stall_count = 5 -> state IDLE, stall_count = 0, mem_wr = 0 immediately (asynchronously). Counter saturation: force 2^CNT_W - 1 stalls -> the counter holds at 0xFFFF.
